// File: rtl/sfx_arbiter.sv
// Sound-effect request arbiter: fixed-priority grant, preemption,
// watchdog abort and enforced silence gap between clips.
module sfx_arbiter #(
  parameter int GAP_TICKS = 120,
  parameter int MAX_TICKS = 24000,
  parameter int PREEMPT   = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] req_in,
  input  logic       sample_tick_in,
  input  logic       done_in,
  input  logic       mute_in,
  output logic       start_out,
  output logic       abort_out,
  output logic [1:0] sel_out,
  output logic       active_out,
  output logic [3:0] pending_out,
  output logic [7:0] drop_count_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_PLAY,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pend_d, clr, drop_v, lo_mask;
  logic [1:0]  idx;
  logic        grant, abort_d;
  logic [15:0] wd_q, wd_d, gap_q, gap_d;
  logic [16:0] wd_inc, gap_inc;
  logic [2:0]  n_drop;
  logic [8:0]  drop_sum;

  assign active_out = (state_q == S_START) || (state_q == S_PLAY);
  assign lo_mask    = (4'b0001 << sel_out) - 4'b0001;
  assign wd_inc     = {1'b0, wd_q} + {16'd0, sample_tick_in};
  assign gap_inc    = {1'b0, gap_q} + {16'd0, sample_tick_in};

  always_comb begin
    idx = 2'd0;
    priority case (1'b1)
      pending_out[0]: idx = 2'd0;
      pending_out[1]: idx = 2'd1;
      pending_out[2]: idx = 2'd2;
      pending_out[3]: idx = 2'd3;
      default:        idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    abort_d = 1'b0;
    wd_d    = wd_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (|pending_out && !mute_in) begin
          grant   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = 16'd0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        wd_d = wd_inc[15:0];
        if (done_in) begin
          state_d = S_GAP;
          gap_d   = 16'd0;
        end else if (mute_in) begin
          abort_d = 1'b1;
          state_d = S_GAP;
          gap_d   = 16'd0;
        end else if (PREEMPT != 0 && |(pending_out & lo_mask)) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (wd_inc == 17'(MAX_TICKS)) begin
          abort_d = 1'b1;
          state_d = S_GAP;
          gap_d   = 16'd0;
        end
      end
      S_GAP: begin
        gap_d = gap_inc[15:0];
        if (gap_inc >= 17'(GAP_TICKS))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request landing on the bit being granted simply re-arms it.
  assign clr      = grant ? (4'b0001 << idx) : 4'b0000;
  assign pend_d   = (pending_out & ~clr) | req_in;
  assign drop_v   = req_in & pending_out & ~clr;
  assign n_drop   = {2'd0, drop_v[0]} + {2'd0, drop_v[1]}
                  + {2'd0, drop_v[2]} + {2'd0, drop_v[3]};
  assign drop_sum = {1'b0, drop_count_out} + {6'd0, n_drop};

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q        <= S_IDLE;
      pending_out    <= 4'd0;
      sel_out        <= 2'd0;
      start_out      <= 1'b0;
      abort_out      <= 1'b0;
      drop_count_out <= 8'd0;
      wd_q           <= 16'd0;
      gap_q          <= 16'd0;
    end else begin
      state_q        <= state_d;
      pending_out    <= pend_d;
      start_out      <= (state_d == S_START);
      abort_out      <= abort_d;
      wd_q           <= wd_d;
      gap_q          <= gap_d;
      if (grant)
        sel_out <= idx;
      drop_count_out <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter with a grant-order scoreboard
// and a PREEMPT=0 companion instance sharing the same stimulus.
module tb_sfx_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [3:0] req_in = 4'd0;
  logic       sample_tick_in = 1'b0;
  logic       done_in = 1'b0;
  logic       mute_in = 1'b0;

  logic       s0_start, s0_abort, s0_active;
  logic [1:0] s0_sel;
  logic [3:0] s0_pend;
  logic [7:0] s0_drop;
  logic       s1_start, s1_abort, s1_active;
  logic [1:0] s1_sel;
  logic [3:0] s1_pend;
  logic [7:0] s1_drop;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk_in = ~clk_in;

  sfx_arbiter #(.GAP_TICKS(120), .MAX_TICKS(8), .PREEMPT(1)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
    .sample_tick_in(sample_tick_in), .done_in(done_in),
    .mute_in(mute_in), .start_out(s0_start), .abort_out(s0_abort),
    .sel_out(s0_sel), .active_out(s0_active),
    .pending_out(s0_pend), .drop_count_out(s0_drop)
  );

  sfx_arbiter #(.GAP_TICKS(2), .MAX_TICKS(8), .PREEMPT(0)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
    .sample_tick_in(sample_tick_in), .done_in(done_in),
    .mute_in(mute_in), .start_out(s1_start), .abort_out(s1_abort),
    .sel_out(s1_sel), .active_out(s1_active),
    .pending_out(s1_pend), .drop_count_out(s1_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] v);
    req_in = v;
    cyc();
    req_in = 4'd0;
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick_in = 1'b1;
      cyc();
      sample_tick_in = 1'b0;
      cyc();
    end
  endtask

  task automatic wait_start();
    int k = 0;
    while (!s0_start && k < 20) begin
      cyc();
      k++;
    end
    chk("wait_start", {31'd0, s0_start}, 32'd1);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    cyc();
    rst_in = 1'b1;
  endtask

  // Scoreboard: every start must match the next expected clip.
  always @(negedge clk_in) begin
    if (s0_start || s0_abort)
      chk("start_abort_excl", {31'd0, s0_start & s0_abort}, 32'd0);
    if (s0_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", {30'd0, s0_sel}, 32'hFFFF_FFFF);
      end else begin
        chk("grant_sel", {30'd0, s0_sel}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_in = 1'b0;
    cyc();
    cyc();
    chk("rst_start", {31'd0, s0_start}, 32'd0);
    chk("rst_abort", {31'd0, s0_abort}, 32'd0);
    chk("rst_sel", {30'd0, s0_sel}, 32'd0);
    chk("rst_active", {31'd0, s0_active}, 32'd0);
    chk("rst_pend", {28'd0, s0_pend}, 32'd0);
    chk("rst_drop", {24'd0, s0_drop}, 32'd0);
    rst_in = 1'b1;
    repeat (8) cyc();

    // Single request: latency, done -> gap of exactly 120 ticks
    exp_q.push_back(1);
    pulse_req(4'b0010);
    chk("single_pend", {28'd0, s0_pend}, 32'h2);
    chk("single_early", {31'd0, s0_start}, 32'd0);
    cyc();
    chk("single_start", {31'd0, s0_start}, 32'd1);
    chk("single_sel", {30'd0, s0_sel}, 32'd1);
    chk("single_active", {31'd0, s0_active}, 32'd1);
    cyc();
    chk("single_pulse1", {31'd0, s0_start}, 32'd0);
    pulse_done();
    chk("gap_active", {31'd0, s0_active}, 32'd0);
    exp_q.push_back(2);
    pulse_req(4'b0100);
    ticks(119);
    chk("gap_119_start", {31'd0, s0_start}, 32'd0);
    chk("gap_119_pend", {28'd0, s0_pend}, 32'h4);
    sample_tick_in = 1'b1;
    cyc();
    sample_tick_in = 1'b0;
    chk("gap_idle_cycle", {31'd0, s0_start}, 32'd0);
    cyc();
    chk("gap_120_start", {31'd0, s0_start}, 32'd1);
    cyc();
    pulse_done();
    ticks(120);
    cyc();

    // Priority: hit before menu, no drops
    exp_q.push_back(2);
    exp_q.push_back(3);
    pulse_req(4'b1100);
    wait_start();
    cyc();
    pulse_done();
    ticks(120);
    wait_start();
    chk("prio_sel3", {30'd0, s0_sel}, 32'd3);
    chk("prio_drop", {24'd0, s0_drop}, 32'd0);
    cyc();

    // Preemption vs. PREEMPT=0 companion
    do_reset();
    exp_q.push_back(3);
    pulse_req(4'b1000);
    wait_start();
    cyc();
    pulse_req(4'b0001);
    chk("pre_abort_early", {31'd0, s0_abort}, 32'd0);
    exp_q.push_back(0);
    cyc();
    chk("pre_abort", {31'd0, s0_abort}, 32'd1);
    chk("pre_idle", {31'd0, s0_active}, 32'd0);
    chk("nopre_abort", {31'd0, s1_abort}, 32'd0);
    chk("nopre_active", {31'd0, s1_active}, 32'd1);
    cyc();
    chk("pre_restart", {31'd0, s0_start}, 32'd1);
    chk("pre_sel0", {30'd0, s0_sel}, 32'd0);
    cyc();
    chk("nopre_still", {31'd0, s1_active}, 32'd1);
    pulse_done();
    ticks(2);
    chk("nopre_start", {31'd0, s1_start}, 32'd1);
    chk("nopre_sel0", {30'd0, s1_sel}, 32'd0);

    // Watchdog: abort once the 8th tick lands, then a full gap
    do_reset();
    exp_q.push_back(2);
    pulse_req(4'b0100);
    wait_start();
    cyc();
    ticks(7);
    chk("wd_7_abort", {31'd0, s0_abort}, 32'd0);
    chk("wd_7_active", {31'd0, s0_active}, 32'd1);
    sample_tick_in = 1'b1;
    cyc();
    sample_tick_in = 1'b0;
    chk("wd_8_abort", {31'd0, s0_abort}, 32'd1);
    chk("wd_8_active", {31'd0, s0_active}, 32'd0);
    cyc();
    chk("wd_abort_pulse", {31'd0, s0_abort}, 32'd0);
    exp_q.push_back(0);
    pulse_req(4'b0001);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wd_gap_hold", {31'd0, s0_start}, 32'd0);
    end
    ticks(120);
    chk("wd_gap_done", {31'd0, s0_start}, 32'd1);

    // Drops saturate while muted
    do_reset();
    mute_in = 1'b1;
    pulse_req(4'b0010);
    req_in = 4'b0010;
    repeat (100) cyc();
    req_in = 4'd0;
    chk("drop_100", {24'd0, s0_drop}, 32'd100);
    req_in = 4'b0010;
    repeat (200) cyc();
    req_in = 4'd0;
    chk("drop_sat", {24'd0, s0_drop}, 32'd255);
    chk("drop_pend", {28'd0, s0_pend}, 32'h2);
    chk("drop_nostart", {31'd0, s0_start}, 32'd0);
    exp_q.push_back(1);
    mute_in = 1'b0;
    cyc();
    chk("unmute_start", {31'd0, s0_start}, 32'd1);
    chk("unmute_sel", {30'd0, s0_sel}, 32'd1);

    // Request colliding with its own grant re-arms without a drop
    do_reset();
    exp_q.push_back(1);
    req_in = 4'b0010;
    cyc();
    cyc();
    req_in = 4'd0;
    chk("rearm_start", {31'd0, s0_start}, 32'd1);
    chk("rearm_pend", {28'd0, s0_pend}, 32'h2);
    chk("rearm_drop", {24'd0, s0_drop}, 32'd0);

    // Reset mid-play, request during reset discarded
    do_reset();
    exp_q.push_back(1);
    pulse_req(4'b0010);
    wait_start();
    cyc();
    pulse_req(4'b0100);
    chk("midrst_pend_pre", {28'd0, s0_pend}, 32'h4);
    chk("midrst_play", {31'd0, s0_active}, 32'd1);
    rst_in = 1'b0;
    req_in = 4'b0001;
    cyc();
    rst_in = 1'b1;
    req_in = 4'd0;
    chk("midrst_abort", {31'd0, s0_abort}, 32'd0);
    chk("midrst_active", {31'd0, s0_active}, 32'd0);
    chk("midrst_pend", {28'd0, s0_pend}, 32'd0);
    chk("midrst_sel", {30'd0, s0_sel}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("midrst_nogrant", {31'd0, s0_start}, 32'd0);
    end
    exp_q.push_back(3);
    pulse_req(4'b1000);
    wait_start();
    cyc();
    mute_in = 1'b1;
    cyc();
    chk("mute_abort", {31'd0, s0_abort}, 32'd1);
    chk("mute_active", {31'd0, s0_active}, 32'd0);
    mute_in = 1'b0;
    cyc();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_arbiter.md
SFX_ARBITER -- requirements
Module: sfx_arbiter

Interface
REQ-001 Parameter GAP_TICKS, default 120: number of sample_tick_in strobes of silence enforced after each sound ends (10 ms at 12 kHz).
REQ-002 Parameter MAX_TICKS, default 24000: watchdog limit in sample_tick_in strobes for one playback (2 s).
REQ-003 Parameter PREEMPT, default 1: when 1, a higher-priority request aborts the sound that is currently playing.
REQ-004 clk_in  input  1  single clock for the block; the audio clock domain.
REQ-005 rst_in  input  1  synchronous, active-low reset, sampled on the rising edge of clk_in.
REQ-006 req_in  input  4  one-cycle request pulses. Bit 0 = hole (highest priority), bit 1 = bounce, bit 2 = hit, bit 3 = menu (lowest).
REQ-007 sample_tick_in  input  1  single-cycle 12 kHz strobe.
REQ-008 done_in  input  1  single-cycle pulse from the playback engine when the selected clip finishes.
REQ-009 mute_in  input  1  level input; while high, no grants are issued.
REQ-010 start_out  output  1  single-cycle pulse that tells the playback engine to start clip sel_out.
REQ-011 abort_out  output  1  single-cycle pulse that tells the playback engine to stop immediately.
REQ-012 sel_out  output  2  index of the granted clip; held stable from start_out until the next grant.
REQ-013 active_out  output  1  high while in states START or PLAY.
REQ-014 pending_out  output  4  the current pending-request register.
REQ-015 drop_count_out  output  8  number of dropped requests, saturating at 255.

Function
REQ-016 Each source SHALL have a depth-1 sticky pending bit, set on the clock edge after its req_in bit is sampled high.
REQ-017 If req_in[i] is high while pending[i] is already set (and is not being cleared that cycle), the request SHALL be dropped and drop_count_out SHALL increment by 1, saturating at 255.
REQ-018 If req_in[i] is high in the same cycle that pending[i] is cleared by a grant, pending[i] SHALL remain set and nothing SHALL be counted as dropped.
REQ-019 The state machine SHALL have exactly four states: IDLE, START, PLAY and GAP.
REQ-020 IDLE: if pending is non-zero and mute_in is 0, the block SHALL, in one cycle, select the lowest set index, load it into sel_out, clear that pending bit, and move to START; otherwise it SHALL stay in IDLE.
REQ-021 START: start_out SHALL be 1 for exactly this one cycle; the watchdog counter SHALL be cleared to 0; the next state SHALL be PLAY.
REQ-022 Grant latency SHALL be: req_in pulse at cycle N -> pending set at N+1 -> grant decision at N+1 -> start_out high at N+2, provided the block is idle and not muted.
REQ-023 PLAY: the watchdog counter SHALL increment on each sample_tick_in. Transitions SHALL be evaluated in this priority order:
  (a) done_in -> GAP.
  (b) mute_in -> abort_out pulse, then GAP.
  (c) PREEMPT=1 and any pending bit with index < sel_out -> abort_out pulse, then IDLE (no gap).
  (d) watchdog count equals MAX_TICKS -> abort_out pulse, then GAP.
REQ-024 GAP: the gap counter SHALL be cleared on entry and SHALL increment on each sample_tick_in; the block SHALL go to IDLE in the cycle the counter reaches GAP_TICKS. With GAP_TICKS=0, GAP SHALL last exactly one cycle.
REQ-025 A done_in pulse that arrives in any state other than PLAY SHALL be ignored.
REQ-026 abort_out and start_out SHALL never be high in the same cycle.
REQ-027 Requests SHALL continue to accumulate in pending during START, PLAY and GAP.
REQ-028 While mute_in is high, pending bits SHALL be retained, and granting SHALL resume on the first IDLE cycle after mute_in falls.
REQ-029 The watchdog and gap counters SHALL each be 16 bits wide; parameter values SHALL be less than 65536.
REQ-030 All outputs SHALL be registered, except active_out, which may be decoded directly from state.

Reset
REQ-031 While rst_in is 0 at a clock edge, the block SHALL take these values on that edge: state = IDLE, pending = 0, sel_out = 0, start_out = 0, abort_out = 0, active_out = 0, drop_count_out = 0, both counters = 0.
REQ-032 Reset asserted during START or PLAY SHALL NOT generate abort_out; the playback engine shares the same reset.
REQ-033 Any req_in pulse sampled in a cycle where rst_in is 0 SHALL be discarded.

Verification
REQ-034 Single request: idle, req_in=4'b0010 at cycle 10 -> start_out=1 at cycle 12 with sel_out=1; done_in pulse -> GAP; IDLE after exactly 120 sample ticks.
REQ-035 Priority: req_in=4'b1100 at cycle 5 -> sel_out=2 granted first; after done_in and the gap, sel_out=3 granted; drop_count_out stays 0.
REQ-036 Preemption: playing sel_out=3, then req_in=4'b0001 -> abort_out pulse on the next cycle, IDLE, then start_out with sel_out=0; with PREEMPT=0, the menu clip plays to done_in first.
REQ-037 Watchdog: grant sel_out=2 and never assert done_in, with MAX_TICKS=8 -> abort_out in the cycle of the 8th sample tick, then GAP.
REQ-038 Drop and saturation: 300 bounce pulses while bit 1 is pending and mute_in=1 -> drop_count_out=255, pending_out=4'b0010, no start_out; release mute_in -> start_out with sel_out=1.
REQ-039 Reset mid-play: rst_in=0 for one cycle during PLAY with pending=4'b0100 -> all outputs at their REQ-031 values, no abort_out, and no grant until a new request arrives.
